ex_mem_sram_ctrl: RTL and testbench

- Multi-cycle controller between the EX-stage result (ALU_Res used as the effective address) and an external 16-bit asynchronous SRAM.
- Sequences each 32-bit load/store as two 16-bit half-word accesses with programmable wait states.
- Drives a `ready` line that freezes the pipeline until the access completes.
- Sits in the MEM stage, fed by EX-stage MEM_R_EN/MEM_W_EN, address and Val_Rm store data.

---
 rtl/ex_mem_sram_ctrl_if.sv | 40 ++++
 rtl/ex_mem_sram_ctrl.sv | 158 +++++++++++++++
 tb/tb_ex_mem_sram_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_sram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_sram_ctrl_if
// Brief    : Bundles the pipeline-side request/response signals and the
//            16-bit asynchronous SRAM pins of the MEM-stage SRAM controller.
// Revision : 1.0 - initial release
// ============================================================================
interface ex_mem_sram_ctrl_if #(
  parameter int DATA_LEN      = 32,
  parameter int ADDRESS_LEN   = 32,
  parameter int SRAM_ADDR_LEN = 18,
  parameter int SRAM_DATA_LEN = 16
);
  // Pipeline side
  logic                     MEM_R_EN;
  logic                     MEM_W_EN;
  logic [ADDRESS_LEN-1:0]   address;
  logic [DATA_LEN-1:0]      write_data;
  logic [DATA_LEN-1:0]      read_data;
  logic                     ready;
  // SRAM side
  logic [SRAM_ADDR_LEN-1:0] sram_addr;
  logic [SRAM_DATA_LEN-1:0] sram_dq_out;
  logic                     sram_dq_oe;
  logic [SRAM_DATA_LEN-1:0] sram_dq_in;
  logic                     sram_we_n;

  // Controller view
  modport slave (
    input  MEM_R_EN, MEM_W_EN, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  // Environment view (pipeline + SRAM device)
  modport master (
    output MEM_R_EN, MEM_W_EN, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface
`default_nettype wire

// File: rtl/ex_mem_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_sram_ctrl
// Brief    : MEM-stage controller that splits each 32-bit load/store into two
//            16-bit SRAM half-word accesses with programmable wait states and
//            stalls the pipeline through 'ready' until the access completes.
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_sram_ctrl #(
  parameter int DATA_LEN      = 32,
  parameter int ADDRESS_LEN   = 32,
  parameter int SRAM_ADDR_LEN = 18,
  parameter int SRAM_DATA_LEN = 16,
  parameter int BASE_ADDR     = 1024,
  parameter int WAIT_CYCLES   = 5
) (
  input  logic              clk,
  input  logic              rst,   // asynchronous, active-low
  ex_mem_sram_ctrl_if.slave bus
);

  localparam int                     CNT_W      = $clog2(WAIT_CYCLES) + 1;
  localparam logic [CNT_W-1:0]       c_CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [ADDRESS_LEN-1:0] c_BASE     = ADDRESS_LEN'(BASE_ADDR);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_LO   = 2'd1;
  localparam logic [1:0] c_HI   = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  // Reject configurations the half-word split cannot support
  generate
    if ((DATA_LEN != 2 * SRAM_DATA_LEN) || (WAIT_CYCLES < 1)) begin : g_param_check
      $error("ex_mem_sram_ctrl: DATA_LEN must be 2*SRAM_DATA_LEN and WAIT_CYCLES >= 1");
    end
  endgenerate

  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   is_wr_q;
  logic [ADDRESS_LEN-1:0] addr_q;
  logic [DATA_LEN-1:0]    wdata_q;
  logic [DATA_LEN-1:0]    rdata_q;

  logic                     w_req;
  logic                     w_last;
  logic [ADDRESS_LEN-1:0]   w_word;
  logic [SRAM_ADDR_LEN-1:0] w_lo_addr;
  logic [SRAM_ADDR_LEN-1:0] w_hi_addr;
  logic                     w_unused_ok;

  // No request is recognised while reset is held, so ready stays high then
  assign w_req  = rst & (bus.MEM_R_EN | bus.MEM_W_EN);
  assign w_last = (cnt_q == c_CNT_LAST);

  // Byte address -> SRAM word; addresses below BASE_ADDR wrap silently
  assign w_word    = (addr_q - c_BASE) >> 2;
  assign w_lo_addr = {w_word[SRAM_ADDR_LEN-2:0], 1'b0};
  assign w_hi_addr = {w_word[SRAM_ADDR_LEN-2:0], 1'b1};
  // Word bits beyond the SRAM address range are dropped on purpose
  assign w_unused_ok = &{1'b0, w_word[ADDRESS_LEN-1:SRAM_ADDR_LEN-1]};

  // State and wait-counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= c_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: each half-word state dwells WAIT_CYCLES cycles, DONE one cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      c_IDLE: begin
        if (w_req) begin
          state_d = c_LO;
          cnt_d   = '0;
        end
      end
      c_LO: begin
        if (w_last) begin
          state_d = c_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      c_HI: begin
        if (w_last) begin
          state_d = c_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  // Request capture on IDLE exit and half-word assembly of load data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == c_IDLE && w_req) begin
        is_wr_q <= bus.MEM_W_EN;   // write wins when both enables are high
        addr_q  <= bus.address;
        wdata_q <= bus.write_data;
      end
      if (state_q == c_LO && !is_wr_q && w_last) begin
        rdata_q[SRAM_DATA_LEN-1:0] <= bus.sram_dq_in;
      end
      if (state_q == c_HI && !is_wr_q && w_last) begin
        rdata_q[DATA_LEN-1:SRAM_DATA_LEN] <= bus.sram_dq_in;
      end
    end
  end

  // Outputs decoded from state so an async reset quiets the SRAM at once
  always_comb begin
    bus.ready       = 1'b0;
    bus.sram_addr   = '0;
    bus.sram_dq_out = '0;
    bus.sram_dq_oe  = 1'b0;
    bus.sram_we_n   = 1'b1;
    bus.read_data   = rdata_q;
    case (state_q)
      c_IDLE: bus.ready = ~w_req;
      c_LO: begin
        bus.sram_addr = w_lo_addr;
        if (is_wr_q) begin
          bus.sram_dq_out = wdata_q[SRAM_DATA_LEN-1:0];
          bus.sram_dq_oe  = 1'b1;
          bus.sram_we_n   = 1'b0;
        end
      end
      c_HI: begin
        bus.sram_addr = w_hi_addr;
        if (is_wr_q) begin
          bus.sram_dq_out = wdata_q[DATA_LEN-1:SRAM_DATA_LEN];
          bus.sram_dq_oe  = 1'b1;
          bus.sram_we_n   = 1'b0;
        end
      end
      default: bus.ready = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_sram_ctrl
// Brief    : Directed self-checking bench for ex_mem_sram_ctrl with a small
//            asynchronous SRAM model that commits a write only after a full
//            WAIT_CYCLES-long write pulse on one address.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mem_sram_ctrl;

  localparam int WAIT_CYCLES = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] mem [0:63];
  int          run_len = 0;
  logic [17:0] last_addr = '0;

  ex_mem_sram_ctrl_if bus ();

  ex_mem_sram_ctrl #(.WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // SRAM read path
  assign bus.sram_dq_in = mem[bus.sram_addr[5:0]];

  // SRAM write path: commit after WAIT_CYCLES consecutive low-we_n edges
  always @(posedge clk) begin
    if (!bus.sram_we_n) begin
      run_len   <= (run_len > 0 && bus.sram_addr == last_addr) ? run_len + 1 : 1;
      last_addr <= bus.sram_addr;
      if (((run_len > 0 && bus.sram_addr == last_addr) ? run_len + 1 : 1) == WAIT_CYCLES)
        mem[bus.sram_addr[5:0]] <= bus.sram_dq_out;
    end else begin
      run_len <= 0;
    end
  end

  task automatic test_reset();
    bus.MEM_R_EN = 1'b0; bus.MEM_W_EN = 1'b0;
    bus.address = '0; bus.write_data = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.ready, bus.sram_we_n, bus.sram_dq_oe, bus.sram_addr, bus.sram_dq_out, bus.read_data}
        !== {1'b1, 1'b1, 1'b0, 18'd0, 16'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_hold: ready=%b we_n=%b oe=%b addr=%0d dq=%h rd=%h, expected 1 1 0 0 0000 00000000",
               bus.ready, bus.sram_we_n, bus.sram_dq_oe, bus.sram_addr, bus.sram_dq_out, bus.read_data);
    end
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.ready, bus.sram_we_n, bus.sram_dq_oe, bus.read_data} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
        errors++;
        $display("FAIL idle cycle %0d: ready=%b we_n=%b oe=%b rd=%h, expected 1 1 0 00000000",
                 k, bus.ready, bus.sram_we_n, bus.sram_dq_oe, bus.read_data);
      end
    end
  endtask

  task automatic test_write();
    logic [17:0] ea; logic [15:0] ed; logic ew, er;
    @(posedge clk); #1;
    bus.MEM_W_EN = 1'b1; bus.address = 32'd1024; bus.write_data = 32'hDEADBEEF;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      er = (k == 11);
      ew = (k >= 1 && k <= 10);
      ea = (k >= 6 && k <= 10) ? 18'd1 : 18'd0;
      ed = (k >= 1 && k <= 5) ? 16'hBEEF : (k >= 6 && k <= 10) ? 16'hDEAD : 16'h0;
      checks++;
      if ({bus.ready, bus.sram_we_n, bus.sram_dq_oe, bus.sram_addr, bus.sram_dq_out} !== {er, ~ew, ew, ea, ed}) begin
        errors++;
        $display("FAIL write cycle %0d: ready=%b we_n=%b oe=%b addr=%0d dq=%h, expected %b %b %b %0d %h",
                 k, bus.ready, bus.sram_we_n, bus.sram_dq_oe, bus.sram_addr, bus.sram_dq_out, er, ~ew, ew, ea, ed);
      end
      @(posedge clk); #1;
      if (k == 0) bus.MEM_W_EN = 1'b0;
    end
    checks++;
    if ({mem[0], mem[1]} !== {16'hBEEF, 16'hDEAD}) begin
      errors++;
      $display("FAIL write_mem: mem0=%h mem1=%h, expected beef dead", mem[0], mem[1]);
    end
  endtask

  task automatic test_read();
    logic [17:0] ea; logic er;
    bus.MEM_R_EN = 1'b1; bus.address = 32'd1028;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      er = (k == 11);
      ea = (k >= 1 && k <= 5) ? 18'd2 : (k >= 6 && k <= 10) ? 18'd3 : 18'd0;
      checks++;
      if ({bus.ready, bus.sram_we_n, bus.sram_dq_oe, bus.sram_addr} !== {er, 1'b1, 1'b0, ea}) begin
        errors++;
        $display("FAIL read cycle %0d: ready=%b we_n=%b oe=%b addr=%0d, expected %b 1 0 %0d",
                 k, bus.ready, bus.sram_we_n, bus.sram_dq_oe, bus.sram_addr, er, ea);
      end
      if (k == 11) begin
        checks++;
        if (bus.read_data !== 32'h12345678) begin
          errors++;
          $display("FAIL read_data: got %h, expected 12345678", bus.read_data);
        end
      end
      @(posedge clk); #1;
      if (k == 0) bus.MEM_R_EN = 1'b0;
    end
  endtask

  task automatic test_simultaneous();
    logic [17:0] ea; logic [15:0] ed; logic ew, er;
    bus.MEM_R_EN = 1'b1; bus.MEM_W_EN = 1'b1;
    bus.address = 32'd1032; bus.write_data = 32'hA5A55A5A;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      er = (k == 11);
      ew = (k >= 1 && k <= 10);
      ea = (k >= 1 && k <= 5) ? 18'd4 : (k >= 6 && k <= 10) ? 18'd5 : 18'd0;
      ed = (k >= 1 && k <= 5) ? 16'h5A5A : (k >= 6 && k <= 10) ? 16'hA5A5 : 16'h0;
      checks++;
      if ({bus.ready, bus.sram_we_n, bus.sram_dq_oe, bus.sram_addr, bus.sram_dq_out} !== {er, ~ew, ew, ea, ed}) begin
        errors++;
        $display("FAIL both_en cycle %0d: ready=%b we_n=%b oe=%b addr=%0d dq=%h, expected %b %b %b %0d %h",
                 k, bus.ready, bus.sram_we_n, bus.sram_dq_oe, bus.sram_addr, bus.sram_dq_out, er, ~ew, ew, ea, ed);
      end
      @(posedge clk); #1;
      if (k == 0) begin bus.MEM_R_EN = 1'b0; bus.MEM_W_EN = 1'b0; end
    end
    checks++;
    if ({mem[4], mem[5], bus.read_data} !== {16'h5A5A, 16'hA5A5, 32'h12345678}) begin
      errors++;
      $display("FAIL both_en_result: mem4=%h mem5=%h rd=%h, expected 5a5a a5a5 12345678",
               mem[4], mem[5], bus.read_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] ea; logic ew, er;
    bus.MEM_W_EN = 1'b1; bus.address = 32'd1040; bus.write_data = 32'hCAFEF00D;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      er = (k == 11 || k == 23);
      ew = (k >= 1 && k <= 10);
      ea = ((k >= 1 && k <= 5) || (k >= 13 && k <= 17)) ? 18'd8 :
           ((k >= 6 && k <= 10) || (k >= 18 && k <= 22)) ? 18'd9 : 18'd0;
      checks++;
      if ({bus.ready, bus.sram_we_n, bus.sram_addr} !== {er, ~ew, ea}) begin
        errors++;
        $display("FAIL b2b cycle %0d: ready=%b we_n=%b addr=%0d, expected %b %b %0d",
                 k, bus.ready, bus.sram_we_n, bus.sram_addr, er, ~ew, ea);
      end
      if (k == 23) begin
        checks++;
        if (bus.read_data !== 32'hCAFEF00D) begin
          errors++;
          $display("FAIL b2b_read_data: got %h, expected cafef00d", bus.read_data);
        end
      end
      @(posedge clk); #1;
      if (k == 0)  bus.MEM_W_EN = 1'b0;
      if (k == 11) begin bus.MEM_R_EN = 1'b1; bus.address = 32'd1040; end
      if (k == 12) bus.MEM_R_EN = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    bus.MEM_W_EN = 1'b1; bus.address = 32'd1036; bus.write_data = 32'h11112222;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.ready, bus.sram_we_n} !== {1'b0, (k == 0)}) begin
        errors++;
        $display("FAIL rstmid cycle %0d: ready=%b we_n=%b, expected 0 %b",
                 k, bus.ready, bus.sram_we_n, (k == 0));
      end
      if (k < 7) begin
        @(posedge clk); #1;
        if (k == 0) bus.MEM_W_EN = 1'b0;
      end
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.ready, bus.sram_we_n, bus.sram_dq_oe, bus.sram_addr, bus.read_data}
        !== {1'b1, 1'b1, 1'b0, 18'd0, 32'h0}) begin
      errors++;
      $display("FAIL rstmid_abort: ready=%b we_n=%b oe=%b addr=%0d rd=%h, expected 1 1 0 0 00000000",
               bus.ready, bus.sram_we_n, bus.sram_dq_oe, bus.sram_addr, bus.read_data);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.ready, bus.sram_we_n, mem[6], mem[7]} !== {1'b1, 1'b1, 16'h2222, 16'hFFFF}) begin
      errors++;
      $display("FAIL rstmid_mem: ready=%b we_n=%b mem6=%h mem7=%h, expected 1 1 2222 ffff",
               bus.ready, bus.sram_we_n, mem[6], mem[7]);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    mem[2] = 16'h5678;
    mem[3] = 16'h1234;
    mem[7] = 16'hFFFF;
    test_reset();
    test_write();
    test_read();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
